// File: rtl/pll_reset_seq.sv
// Reset and lock sequencer for the core PLL: pulses the PLL reset, qualifies lock,
// holds the system reset until lock has been stable, and counts lock losses/timeouts.
module pll_reset_seq #(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 65536,
   parameter int STABLE_CYCLES  = 1024,
   parameter int CNT_W          = 8
) (
   input  logic             inclk0,
   input  logic             areset_n,
   input  logic             pll_locked,
   input  logic             soft_reset,
   output logic             pll_rst,
   output logic             sys_reset,
   output logic             ready,
   output logic [CNT_W-1:0] lock_loss_cnt,
   output logic [CNT_W-1:0] timeout_cnt,
   output logic [1:0]       dbg_state
);

   localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_P = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
   localparam int CW    = $clog2(MAX_P);

   localparam logic [CW-1:0]    RST_LAST    = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0]    WAIT_LAST   = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0]    STABLE_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0]    CNT_ONE     = CW'(1);
   localparam logic [CNT_W-1:0] DIAG_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] DIAG_ONE    = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_PLLRST = 2'd0,
      ST_WAIT   = 2'd1,
      ST_STABLE = 2'd2,
      ST_RUN    = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0] lock_loss_cnt_q, lock_loss_cnt_d;
   logic [CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;
   logic             pll_rst_q, pll_rst_d;
   logic             sys_reset_q, sys_reset_d;
   logic             ready_q, ready_d;
   logic             sync1_q, locked_s_q;

   // pll_locked comes from the PLL with no relation to inclk0.
   always_ff @(posedge inclk0 or negedge areset_n) begin
      if (!areset_n) begin
         sync1_q    <= 1'b0;
         locked_s_q <= 1'b0;
      end else begin
         sync1_q    <= pll_locked;
         locked_s_q <= sync1_q;
      end
   end

   always_ff @(posedge inclk0 or negedge areset_n) begin
      if (!areset_n) begin
         state_q         <= ST_PLLRST;
         cnt_q           <= '0;
         lock_loss_cnt_q <= '0;
         timeout_cnt_q   <= '0;
         pll_rst_q       <= 1'b1;
         sys_reset_q     <= 1'b1;
         ready_q         <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         lock_loss_cnt_q <= lock_loss_cnt_d;
         timeout_cnt_q   <= timeout_cnt_d;
         pll_rst_q       <= pll_rst_d;
         sys_reset_q     <= sys_reset_d;
         ready_q         <= ready_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q + CNT_ONE;
      lock_loss_cnt_d = lock_loss_cnt_q;
      timeout_cnt_d   = timeout_cnt_q;

      case (state_q)
         ST_PLLRST: begin
            if (cnt_q == RST_LAST) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (locked_s_q) begin
               state_d = ST_STABLE;
            end else if (cnt_q == WAIT_LAST) begin
               state_d = ST_PLLRST;
               if (timeout_cnt_q != DIAG_MAX) timeout_cnt_d = timeout_cnt_q + DIAG_ONE;
            end
         end
         ST_STABLE: begin
            if (!locked_s_q) begin
               state_d = ST_WAIT;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // The counter is idle in RUN; lock loss wins over a soft reset request.
            cnt_d = cnt_q;
            if (!locked_s_q) begin
               state_d = ST_PLLRST;
               if (lock_loss_cnt_q != DIAG_MAX) lock_loss_cnt_d = lock_loss_cnt_q + DIAG_ONE;
            end else if (soft_reset) begin
               state_d = ST_STABLE;
            end
         end
         default: state_d = ST_PLLRST;
      endcase

      if (state_d != state_q) cnt_d = '0;

      // Decoded from the next state so the registered outputs move with the state.
      pll_rst_d   = (state_d == ST_PLLRST);
      sys_reset_d = (state_d != ST_RUN);
      ready_d     = (state_d == ST_RUN);
   end

   assign pll_rst       = pll_rst_q;
   assign sys_reset     = sys_reset_q;
   assign ready         = ready_q;
   assign lock_loss_cnt = lock_loss_cnt_q;
   assign timeout_cnt   = timeout_cnt_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with short sequencing parameters (4/32/8, 4-bit counters).
module tb_pll_reset_seq;

   localparam int CW = 4;

   logic          inclk0;
   logic          areset_n;
   logic          pll_locked;
   logic          soft_reset;
   logic          pll_rst;
   logic          sys_reset;
   logic          ready;
   logic [CW-1:0] lock_loss_cnt;
   logic [CW-1:0] timeout_cnt;
   logic [1:0]    dbg_state;

   int tests_run = 0;
   int fails     = 0;

   pll_reset_seq #(
      .PLL_RST_CYCLES(4),
      .LOCK_TIMEOUT  (32),
      .STABLE_CYCLES (8),
      .CNT_W         (CW)
   ) dut (
      .inclk0       (inclk0),
      .areset_n     (areset_n),
      .pll_locked   (pll_locked),
      .soft_reset   (soft_reset),
      .pll_rst      (pll_rst),
      .sys_reset    (sys_reset),
      .ready        (ready),
      .lock_loss_cnt(lock_loss_cnt),
      .timeout_cnt  (timeout_cnt),
      .dbg_state    (dbg_state)
   );

   initial inclk0 = 1'b0;
   always #5 inclk0 = ~inclk0;

   // Leaves areset_n released #1 after an edge, so the next rising edge is edge 1.
   task automatic do_reset();
      areset_n   = 1'b0;
      soft_reset = 1'b0;
      repeat (2) @(posedge inclk0);
      #1;
      areset_n = 1'b1;
   endtask

   task automatic test_reset();
      pll_locked = 1'b1;
      soft_reset = 1'b0;
      areset_n   = 1'b0;
      repeat (3) @(posedge inclk0);
      #1;
      tests_run++;
      if ({pll_rst, sys_reset, ready} !== 3'b110) begin
         fails++;
         $display("FAIL reset_outputs got %b exp 110", {pll_rst, sys_reset, ready});
      end
      tests_run++;
      if ({lock_loss_cnt, timeout_cnt} !== 8'h00) begin
         fails++;
         $display("FAIL reset_counters got %h exp 00", {lock_loss_cnt, timeout_cnt});
      end
      tests_run++;
      if (dbg_state !== 2'd0) begin
         fails++;
         $display("FAIL reset_state got %0d exp 0", dbg_state);
      end
   endtask

   task automatic test_clean_start();
      logic [2:0] exp;
      pll_locked = 1'b1;
      do_reset();
      for (int e = 1; e <= 15; e++) begin
         @(posedge inclk0);
         #1;
         exp = {(e < 4) ? 1'b1 : 1'b0, (e < 13) ? 1'b1 : 1'b0, (e >= 13) ? 1'b1 : 1'b0};
         tests_run++;
         if ({pll_rst, sys_reset, ready} !== exp) begin
            fails++;
            $display("FAIL clean_start e=%0d got %b exp %b", e, {pll_rst, sys_reset, ready}, exp);
         end
      end
      tests_run++;
      if ({lock_loss_cnt, timeout_cnt} !== 8'h00) begin
         fails++;
         $display("FAIL clean_counters got %h exp 00", {lock_loss_cnt, timeout_cnt});
      end
   endtask

   task automatic test_lock_loss();
      logic [2:0] exp;
      pll_locked = 1'b1;
      do_reset();
      repeat (13) @(posedge inclk0);
      #1;
      pll_locked = 1'b0;
      for (int e = 1; e <= 18; e++) begin
         @(posedge inclk0);
         #1;
         if (e == 3) pll_locked = 1'b1;
         exp = {(e >= 3 && e < 7) ? 1'b1 : 1'b0, (e >= 3 && e < 16) ? 1'b1 : 1'b0,
                (e < 3 || e >= 16) ? 1'b1 : 1'b0};
         tests_run++;
         if ({pll_rst, sys_reset, ready} !== exp) begin
            fails++;
            $display("FAIL lock_loss e=%0d got %b exp %b", e, {pll_rst, sys_reset, ready}, exp);
         end
         if (e == 3) begin
            tests_run++;
            if (lock_loss_cnt !== 4'd1) begin
               fails++;
               $display("FAIL lock_loss_cnt got %0d exp 1", lock_loss_cnt);
            end
         end
      end
      tests_run++;
      if ({lock_loss_cnt, timeout_cnt} !== 8'h10) begin
         fails++;
         $display("FAIL lock_loss_counters got %h exp 10", {lock_loss_cnt, timeout_cnt});
      end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 2; k++) begin
         pll_locked = 1'b0;
         repeat (3) @(posedge inclk0);
         #1;
         pll_locked = 1'b1;
         repeat (13) @(posedge inclk0);
         #1;
      end
      tests_run++;
      if ({ready, lock_loss_cnt} !== 5'b1_0011) begin
         fails++;
         $display("FAIL mid_precond got %b exp 10011", {ready, lock_loss_cnt});
      end
      #2;
      areset_n = 1'b0;
      #1;
      tests_run++;
      if ({pll_rst, sys_reset, ready, dbg_state} !== 5'b110_00) begin
         fails++;
         $display("FAIL mid_async_outputs got %b exp 11000", {pll_rst, sys_reset, ready, dbg_state});
      end
      tests_run++;
      if ({lock_loss_cnt, timeout_cnt} !== 8'h00) begin
         fails++;
         $display("FAIL mid_async_counters got %h exp 00", {lock_loss_cnt, timeout_cnt});
      end
   endtask

   task automatic test_glitch();
      logic [1:0] exp;
      pll_locked = 1'b1;
      do_reset();
      for (int e = 1; e <= 23; e++) begin
         pll_locked = (e != 10);
         @(posedge inclk0);
         #1;
         exp = {(e < 4) ? 1'b1 : 1'b0, (e < 21) ? 1'b1 : 1'b0};
         tests_run++;
         if ({pll_rst, sys_reset} !== exp) begin
            fails++;
            $display("FAIL glitch e=%0d got %b exp %b", e, {pll_rst, sys_reset}, exp);
         end
         if (e == 12) begin
            tests_run++;
            if (dbg_state !== 2'd1) begin
               fails++;
               $display("FAIL glitch_wait_state got %0d exp 1", dbg_state);
            end
         end
      end
      pll_locked = 1'b1;
   endtask

   task automatic test_soft_reset();
      logic [2:0] exp;
      // Starts in RUN, left there by test_glitch.
      soft_reset = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         @(posedge inclk0);
         #1;
         soft_reset = 1'b0;
         exp = {1'b0, (e < 9) ? 1'b1 : 1'b0, (e >= 9) ? 1'b1 : 1'b0};
         tests_run++;
         if ({pll_rst, sys_reset, ready} !== exp) begin
            fails++;
            $display("FAIL soft_reset e=%0d got %b exp %b", e, {pll_rst, sys_reset, ready}, exp);
         end
      end
      // soft_reset held through WAIT must not disturb the lock timeout.
      pll_locked = 1'b0;
      do_reset();
      for (int e = 1; e <= 37; e++) begin
         if (e >= 6) soft_reset = 1'b1;
         @(posedge inclk0);
         #1;
         if (e == 20) begin
            tests_run++;
            if ({dbg_state, sys_reset, pll_rst} !== 4'b01_1_0) begin
               fails++;
               $display("FAIL soft_in_wait got %b exp 0110", {dbg_state, sys_reset, pll_rst});
            end
         end
         if (e == 36) begin
            tests_run++;
            if ({pll_rst, timeout_cnt} !== 5'b1_0001) begin
               fails++;
               $display("FAIL soft_in_wait_timeout got %b exp 10001", {pll_rst, timeout_cnt});
            end
         end
      end
      soft_reset = 1'b0;
   endtask

   task automatic test_timeout();
      logic [CW-1:0] exp_to;
      logic          exp_rst;
      pll_locked = 1'b0;
      do_reset();
      for (int e = 1; e <= 590; e++) begin
         @(posedge inclk0);
         #1;
         exp_rst = ((e % 36) < 4);
         exp_to  = ((e / 36) > 15) ? 4'd15 : CW'(e / 36);
         tests_run++;
         if ({pll_rst, sys_reset, ready, timeout_cnt} !== {exp_rst, 1'b1, 1'b0, exp_to}) begin
            fails++;
            $display("FAIL timeout e=%0d got rst=%b sys=%b rdy=%b to=%0d exp rst=%b sys=1 rdy=0 to=%0d",
                     e, pll_rst, sys_reset, ready, timeout_cnt, exp_rst, exp_to);
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_start();
      test_lock_loss();
      test_reset_mid();
      test_glitch();
      test_soft_reset();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule

// File: doc/pll_reset_seq.md
# pll_reset_seq

Reset and lock sequencer between the board reference clock and the core PLL. Runs on the PLL reference clock, so it keeps running while the PLL is unlocked. Drives the PLL reset, qualifies the PLL `locked` flag, and releases a system reset only after lock has been stable for a programmable time. Re-sequences on lock loss or lock timeout and keeps saturating diagnostic counters.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per attempt (≥2).
- `LOCK_TIMEOUT`, 65536: cycles to wait for lock before re-pulsing `pll_rst` (≥4).
- `STABLE_CYCLES`, 1024: cycles lock must stay continuously high before `sys_reset` releases (≥2).
- `CNT_W`, 8: width of the diagnostic counters.

Ports (one clock; reset is asynchronous and active-low):
- `inclk0` in 1: reference clock (50 MHz), same net that feeds the PLL.
- `areset_n` in 1: asynchronous active-low reset; assertion is immediate, deassertion is sampled by `inclk0`.
- `pll_locked` in 1: PLL lock flag, asynchronous to `inclk0`.
- `soft_reset` in 1: synchronous active-high request to re-run the stability hold without resetting the PLL.
- `pll_rst` out 1: active-high reset to the PLL.
- `sys_reset` out 1: active-high core reset. Consumers synchronise it into their own domains.
- `ready` out 1: high only in RUN.
- `lock_loss_cnt` out CNT_W: number of RUN→PLLRST transitions, saturating.
- `timeout_cnt` out CNT_W: number of lock timeouts, saturating.

## Operation
- `pll_locked` passes through a 2-flop synchroniser (reset 0) to give `locked_s`. Only `locked_s` is used.
- A single counter `cnt` of width clog2(max parameter) is cleared on every state change.
- State machine:
  - **PLLRST**: `pll_rst`=1. When `cnt`==PLL_RST_CYCLES-1, go to WAIT.
  - **WAIT**: if `locked_s`, go to STABLE. Otherwise, when `cnt`==LOCK_TIMEOUT-1, go to PLLRST and increment `timeout_cnt`.
  - **STABLE**: if `!locked_s`, go to WAIT (fresh timeout). When `cnt`==STABLE_CYCLES-1, go to RUN.
  - **RUN**: if `!locked_s`, go to PLLRST and increment `lock_loss_cnt`. Else if `soft_reset`, go to STABLE.
- `locked_s` has priority over `soft_reset` in RUN.
- `soft_reset` is ignored outside RUN.
- Output decode:
  - `pll_rst` = (state==PLLRST).
  - `sys_reset` = (state!=RUN).
  - `ready` = (state==RUN).
- Outputs are registered from the next-state decode, so they are glitch-free and change on the same edge as the state.
- Diagnostic counters saturate at 2^CNT_W-1 and clear only on `areset_n`.

## Timing
- During `areset_n` low:
  - state=PLLRST, `cnt`=0, `locked_s`=0.
  - `pll_rst`=1, `sys_reset`=1, `ready`=0, `lock_loss_cnt`=0, `timeout_cnt`=0.
- Deasserting `areset_n` starts PLLRST counting on the first `inclk0` rising edge.
- Lock-to-visible latency is 2 cycles (synchroniser). Lock-loss-to-`sys_reset` latency is 3 cycles: 2 synchroniser plus 1 state register.
- Minimum release time with `pll_locked` high throughout is PLL_RST_CYCLES + 1 + STABLE_CYCLES edges after reset deassertion.
- `pll_rst` pulse width is exactly PLL_RST_CYCLES cycles.
- A `locked_s` glitch in STABLE restarts the full stability hold.
- `areset_n` asserted mid-sequence returns immediately to reset values, including the counters.

## Test plan
Parameters for all scenarios: PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, CNT_W=4.
- **Clean start:** `pll_locked`=1 from time 0, release `areset_n` → `pll_rst` falls on edge 4, `sys_reset` falls and `ready` rises on edge 13, both counters 0.
- **Timeout:** `pll_locked`=0 → `pll_rst` re-pulses for 4 cycles every 36 cycles; `timeout_cnt` increments each time and saturates at 15 after 15 timeouts.
- **Lock loss in RUN:** drop `pll_locked` → `sys_reset`=1 three edges later, `pll_rst`=1 for 4 cycles, `lock_loss_cnt`=1. After relock, `ready` returns after the full sequence.
- **Glitch in STABLE:** 1-cycle low on `pll_locked` at stable cycle 5 → back to WAIT; `sys_reset` release is delayed by the full 8-cycle hold counted from relock.
- **Soft reset:** 1-cycle `soft_reset` in RUN → `sys_reset` high for 8 cycles, `pll_rst` stays 0. `soft_reset` in WAIT has no effect.
- **Reset mid-operation:** assert `areset_n` low in RUN with `lock_loss_cnt`=3 → all outputs return to reset values asynchronously, counter reads 0.
